apb_master_arbiter: RTL and testbench

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_arb_pkg.sv | 18 +
 rtl/rr_grant.sv | 31 +++
 rtl/apb_master_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
// FSM encoding, APB widths and the PSEL decode field position.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_NSLV   = 16;
  localparam int PSEL_LSB   = 24;
  localparam int PSEL_MSB   = 27;

endpackage

// File: rtl/rr_grant.sv
// Round-robin one-hot grant.
// ptr is the highest-priority index (one past the last grant).
module rr_grant
  import apb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  // scan from ptr upward, wrapping, take the first request
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// N-requester round-robin arbiter driving one APB master port.
// Optional PREADY timeout: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       PCLK,
  input  logic                       PRESETN,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*APB_ADDR_W-1:0] req_addr,
  input  logic [NREQ*APB_DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [APB_DATA_W-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic [APB_NSLV-1:0]        PSEL,
  output logic [APB_ADDR_W-1:0]      PADDR,
  output logic                       PWRITE,
  output logic                       PENABLE,
  output logic [APB_DATA_W-1:0]      PWDATA,
  input  logic [APB_DATA_W-1:0]      PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);

  localparam int PW = $clog2(NREQ);

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         gidx_q, gidx_d;
  logic [PW-1:0]         gsel;
  logic                  write_q, write_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [NREQ-1:0]       gnt;
  logic                  tmo;

  rr_grant #(.N(NREQ), .PW(PW)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // one-hot grant to index
  always_comb begin
    gsel = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) gsel = PW'(i);
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // ACCESS cycle counter, cleared while in SETUP
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SETUP)
      cnt_d = '0;
    else if (state_q == S_ACCESS)
      cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // next state, grant capture and response capture
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d = S_SETUP;
          gidx_d  = gsel;
          ptr_d   = (gsel == PW'(NREQ - 1)) ? '0 : gsel + 1'b1;
          write_d = req_write[gsel];
          addr_d  = req_addr[APB_ADDR_W*gsel +: APB_ADDR_W];
          wdata_d = req_wdata[APB_DATA_W*gsel +: APB_DATA_W];
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          state_d = S_RESP;
          rdata_d = write_q ? '0 : PRDATA;
          err_d   = PSLVERR;
        end else if (tmo) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // state-decoded handshakes and APB strobes
  always_comb begin
    PSEL      = '0;
    PENABLE   = 1'b0;
    rsp_valid = '0;
    req_ready = '0;
    if (state_q == S_SETUP || state_q == S_ACCESS)
      PSEL[addr_q[PSEL_MSB:PSEL_LSB]] = 1'b1;
    if (state_q == S_ACCESS)
      PENABLE = 1'b1;
    if (state_q == S_RESP)
      rsp_valid[gidx_q] = 1'b1;
    if (state_q == S_IDLE && PRESETN)
      req_ready = gnt;
  end

  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed table, corner sequences
// and randomized transfers against a transaction-level model.
module tb_apb_master_arbiter;

  localparam int NREQ = 4;
  localparam int TCYC = 8;

  logic             PCLK, PRESETN;
  logic [NREQ-1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*32-1:0] req_addr, req_wdata;
  logic [31:0]      rsp_rdata, PADDR, PWDATA, PRDATA;
  logic             rsp_err, PWRITE, PENABLE, PREADY, PSLVERR;
  logic [15:0]      PSEL;

  int n_cmp = 0;
  int n_err = 0;
  int ptr   = 0;

  apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TCYC)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // round-robin choice from the rules: first valid at or after ptr
  function automatic int rr_pick(input logic [NREQ-1:0] vm);
    for (int k = 0; k < NREQ; k++)
      if (vm[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic drive_reqs(input logic [NREQ-1:0] vm, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int g);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = vm[i];
      req_write[i] = wr;
      req_addr[i*32 +: 32]  = a ^ 32'((i ^ g) << 2);
      req_wdata[i*32 +: 32] = wd ^ 32'(i ^ g);
    end
  endtask

  // one full transfer starting from IDLE
  task automatic xfer(input logic [NREQ-1:0] vm, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd,
                      input logic er, input int g,
                      input logic [15:0] psel, input logic hold);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << g;
    @(negedge PCLK);
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_psel", PSEL, 0);
    drive_reqs(vm, wr, a, wd, g);
    #1;
    chk("grant", req_ready, oh);
    ptr = (g + 1) % NREQ;
    @(negedge PCLK);
    if (!hold) req_valid = '0;
    #1;
    chk("setup_psel", PSEL, psel);
    chk("setup_pen", PENABLE, 0);
    chk("setup_addr", PADDR, a);
    chk("setup_wr", PWRITE, wr);
    chk("setup_wdata", PWDATA, wd);
    chk("setup_rdy", req_ready, 0);
    for (int k = 0; k <= waits; k++) begin
      @(negedge PCLK);
      chk("acc_pen", PENABLE, 1);
      chk("acc_psel", PSEL, psel);
      chk("acc_rdy", req_ready, 0);
      chk("acc_rsp", rsp_valid, 0);
      PREADY  = (k == waits);
      PRDATA  = (k == waits) ? rd : $urandom;
      PSLVERR = (k == waits) ? er : 1'($urandom);
    end
    @(negedge PCLK);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    req_valid = '0;
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_rdata", rsp_rdata, wr ? 32'h0 : rd);
    chk("rsp_err", rsp_err, er);
    chk("rsp_psel", PSEL, 0);
    chk("rsp_pen", PENABLE, 0);
    chk("rsp_addr_hold", PADDR, a);
  endtask

  typedef struct {
    logic [NREQ-1:0] vm;
    logic            wr;
    logic [31:0]     a, wd, rd;
    int              waits;
    logic            er;
    int              g;
    logic [15:0]     psel;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [NREQ-1:0] vm;
    logic [31:0] a;
    int g, en, t;
    logic done;

    tbl[0] = '{4'b0001, 1'b1, 32'h0200_0004, 32'hA5A5_0001, 32'h0,
               0, 1'b0, 0, 16'h0004};
    tbl[1] = '{4'b0010, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678,
               3, 1'b0, 1, 16'h0001};
    tbl[2] = '{4'b0100, 1'b1, 32'h0F00_0000, 32'hDEAD_BEEF, 32'h0,
               1, 1'b1, 2, 16'h8000};
    tbl[3] = '{4'b1011, 1'b0, 32'h0300_0020, 32'h0, 32'hCAFE_F00D,
               0, 1'b0, 3, 16'h0008};
    tbl[4] = '{4'b0110, 1'b0, 32'h0A00_0000, 32'h0, 32'h0BAD_0001,
               2, 1'b1, 1, 16'h0400};
    tbl[5] = '{4'b1001, 1'b1, 32'h0500_0100, 32'h1, 32'h0,
               0, 1'b0, 3, 16'h0020};

    PRESETN = 1'b0;
    req_valid = '1;
    req_write = '1;
    req_addr  = '1;
    req_wdata = '1;
    PRDATA = '0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_pen", PENABLE, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    req_valid = '0;
    @(negedge PCLK);
    PRESETN = 1'b1;

    for (int i = 0; i < 6; i++)
      xfer(tbl[i].vm, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].waits,
           tbl[i].rd, tbl[i].er, tbl[i].g, tbl[i].psel, 1'b1);

    // reset during ACCESS
    @(negedge PCLK);
    drive_reqs(4'b1000, 1'b0, 32'h0100_0000, 32'h0, 3);
    #1;
    chk("mid_grant", req_ready, 4'b1000);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("mid_pen", PENABLE, 1);
    #2;
    PRESETN = 1'b0;
    #1;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_pen", PENABLE, 0);
    PREADY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge PCLK);
      chk("mid_rst_rsp", rsp_valid, 0);
    end
    req_valid = '0;
    PREADY = 1'b0;
    PRESETN = 1'b1;
    ptr = 0;
    @(negedge PCLK);
    chk("post_rst_rsp", rsp_valid, 0);

    // fairness: all held valid
    for (int k = 0; k < 5; k++)
      xfer(4'b1111, 1'b1, 32'h0600_0040 + 32'(k), 32'h100 + 32'(k),
           0, 32'h0, 1'b0, k % 4, 16'h0040, 1'b1);

`ifdef APB_ARB_TIMEOUT_EN
    @(negedge PCLK);
    g = rr_pick(4'b0010);
    drive_reqs(4'b0010, 1'b0, 32'h0300_0000, 32'h0, g);
    #1;
    chk("tmo_grant", req_ready, 4'b0010);
    ptr = (g + 1) % NREQ;
    @(negedge PCLK);
    req_valid = '0;
    PRDATA = 32'hFFFF_FFFF;
    en = 0;
    done = 1'b0;
    for (t = 0; t < 60 && !done; t++) begin
      @(negedge PCLK);
      if (rsp_valid != 0) done = 1'b1;
      else if (PENABLE) en++;
    end
    chk("tmo_reached", done, 1);
    chk("tmo_cycles", en, TCYC);
    chk("tmo_rsp", rsp_valid, 4'b0010);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_rdata", rsp_rdata, 0);
    @(negedge PCLK);
    chk("tmo_idle_psel", PSEL, 0);
    chk("tmo_idle_rsp", rsp_valid, 0);
`endif

    // randomized transfers against the round-robin model
    for (int n = 0; n < 40; n++) begin
      vm = NREQ'($urandom_range(1, 15));
      g  = rr_pick(vm);
      a  = $urandom;
      xfer(vm, 1'($urandom), a, $urandom, $urandom_range(0, 4),
           $urandom, 1'($urandom), g, 16'(1) << a[27:24],
           1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
